// File: rtl/issue_scheduler_pkg.sv
// Shared parameters, payload structs and helpers for the reservation-station scheduler.
package issue_scheduler_pkg;

  localparam int unsigned RS_ENTRIES = 8;
  localparam int unsigned NUM_PREGS  = 128;
  localparam int unsigned NUM_FUS    = 4;
  localparam int unsigned TAG_W      = $clog2(NUM_PREGS);
  localparam int unsigned FU_W       = $clog2(NUM_FUS);
  localparam int unsigned IDX_W      = $clog2(RS_ENTRIES);
  localparam int unsigned OCC_W      = $clog2(RS_ENTRIES) + 1;
  localparam int unsigned IMM_W      = 32;

  // Issue payload handed to register read.
  typedef struct packed {
    logic [TAG_W-1:0] src1_index;
    logic [TAG_W-1:0] src2_index;
    logic [IMM_W-1:0] imm_val;
    logic [TAG_W-1:0] dst_index;
  } sel_uop_t;

  // One reservation-station slot.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] src1_tag;
    logic             src1_rdy;
    logic [TAG_W-1:0] src2_tag;
    logic             src2_rdy;
    logic [TAG_W-1:0] dst_tag;
    logic [FU_W-1:0]  fu;
    logic [IMM_W-1:0] imm;
  } rs_entry_t;

  // True when any valid writeback lane broadcasts the given tag.
  function automatic logic tag_hit(input logic [TAG_W-1:0]         tag,
                                   input logic [NUM_FUS-1:0]       wb_valid,
                                   input logic [NUM_FUS*TAG_W-1:0] wb_tag);
    logic hit;
    hit = 1'b0;
    for (int f = 0; f < NUM_FUS; f++) begin
      if (wb_valid[f] && (wb_tag[f*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/issue_scheduler_age_select.sv
// Oldest-first picker: grants the candidate that has no older candidate.
// Ports: cand (candidate vector), older[i][j] (j older than i), grant_c (one-hot, comb).
module rs_age_select
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned N = RS_ENTRIES
) (
  input  logic [N-1:0]        cand,
  input  logic [N-1:0][N-1:0] older,
  output logic [N-1:0]        grant_c
);

  always_comb begin
    grant_c = '0;
    for (int i = 0; i < N; i++) begin
      grant_c[i] = cand[i] && ((cand & older[i]) == '0);
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Wakeup/select scheduler: holds renamed uops, snoops writeback tags, and
// issues the oldest ready uop to each non-busy functional unit.
// Ports: clk/rst (async high), flush; dispatch disp_* with disp_ready;
// wb_valid/wb_tag wakeup lanes; fu_busy; iss_valid/iss_uop (comb); occupancy.
module issue_scheduler
  import issue_scheduler_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [TAG_W-1:0]         disp_src1_tag,
  input  logic [TAG_W-1:0]         disp_src2_tag,
  input  logic                     disp_src1_rdy,
  input  logic                     disp_src2_rdy,
  input  logic [TAG_W-1:0]         disp_dst_tag,
  input  logic [FU_W-1:0]          disp_fu,
  input  logic [IMM_W-1:0]         disp_imm,
  input  logic [NUM_FUS-1:0]       wb_valid,
  input  logic [NUM_FUS*TAG_W-1:0] wb_tag,
  input  logic [NUM_FUS-1:0]       fu_busy,
  output logic [NUM_FUS-1:0]       iss_valid,
  output sel_uop_t [NUM_FUS-1:0]   iss_uop,
  output logic [OCC_W-1:0]         occupancy
);

  rs_entry_t                              entries     [RS_ENTRIES];
  rs_entry_t                              entries_nxt [RS_ENTRIES];
  logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0]  older, older_nxt;
  logic [OCC_W-1:0]                       occ_nxt;
  logic [RS_ENTRIES-1:0]                  valid_vec, ready_vec, issue_vec;
  logic [NUM_FUS-1:0][RS_ENTRIES-1:0]     cand, grant_raw, grant;
  logic [OCC_W-1:0]                       grant_cnt;
  logic [IDX_W-1:0]                       alloc_idx;
  logic                                   disp_fire;

  // Full check uses registered occupancy only, so same-cycle frees don't help.
  assign disp_ready = (occupancy != OCC_W'(RS_ENTRIES));
  assign disp_fire  = disp_valid && disp_ready && !flush;

  // Readiness and per-FU candidate vectors from registered state.
  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    cand      = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      valid_vec[i] = entries[i].valid;
      ready_vec[i] = entries[i].valid && entries[i].src1_rdy && entries[i].src2_rdy;
      for (int f = 0; f < NUM_FUS; f++) begin
        cand[f][i] = ready_vec[i] && (entries[i].fu == FU_W'(f));
      end
    end
  end

  for (genvar f = 0; f < NUM_FUS; f++) begin : g_sel
    rs_age_select #(.N(RS_ENTRIES)) u_sel (
      .cand    (cand[f]),
      .older   (older),
      .grant_c (grant_raw[f])
    );
  end

  // A busy FU suppresses its grant; the winner stays put and keeps its age.
  always_comb begin
    grant     = '0;
    issue_vec = '0;
    grant_cnt = '0;
    iss_valid = '0;
    iss_uop   = '0;
    for (int f = 0; f < NUM_FUS; f++) begin
      grant[f]     = fu_busy[f] ? '0 : grant_raw[f];
      iss_valid[f] = |grant[f];
      issue_vec    = issue_vec | grant[f];
      grant_cnt    = grant_cnt + OCC_W'(iss_valid[f]);
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (grant[f][i]) begin
          iss_uop[f].src1_index = entries[i].src1_tag;
          iss_uop[f].src2_index = entries[i].src2_tag;
          iss_uop[f].imm_val    = entries[i].imm;
          iss_uop[f].dst_index  = entries[i].dst_tag;
        end
      end
    end
  end

  // Lowest-index free slot.
  always_comb begin
    alloc_idx = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) alloc_idx = IDX_W'(i);
    end
  end

  // Next state: wakeup, issue free, dispatch allocate, then flush override.
  always_comb begin
    entries_nxt = entries;
    older_nxt   = older;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (entries[i].valid) begin
        entries_nxt[i].src1_rdy = entries[i].src1_rdy || tag_hit(entries[i].src1_tag, wb_valid, wb_tag);
        entries_nxt[i].src2_rdy = entries[i].src2_rdy || tag_hit(entries[i].src2_tag, wb_valid, wb_tag);
      end
      if (issue_vec[i]) entries_nxt[i].valid = 1'b0;
    end
    if (disp_fire) begin
      entries_nxt[alloc_idx].valid    = 1'b1;
      entries_nxt[alloc_idx].src1_tag = disp_src1_tag;
      entries_nxt[alloc_idx].src1_rdy = disp_src1_rdy || tag_hit(disp_src1_tag, wb_valid, wb_tag);
      entries_nxt[alloc_idx].src2_tag = disp_src2_tag;
      entries_nxt[alloc_idx].src2_rdy = disp_src2_rdy || tag_hit(disp_src2_tag, wb_valid, wb_tag);
      entries_nxt[alloc_idx].dst_tag  = disp_dst_tag;
      entries_nxt[alloc_idx].fu       = disp_fu;
      entries_nxt[alloc_idx].imm      = disp_imm;
      for (int r = 0; r < RS_ENTRIES; r++) older_nxt[r][alloc_idx] = 1'b0;
      // Everything surviving this edge is older than the newcomer.
      older_nxt[alloc_idx] = valid_vec & ~issue_vec;
    end
    occ_nxt = occupancy + OCC_W'(disp_fire) - grant_cnt;
    if (flush) begin
      for (int i = 0; i < RS_ENTRIES; i++) entries_nxt[i].valid = 1'b0;
      older_nxt = '0;
      occ_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_ENTRIES; i++) entries[i] <= '0;
      older     <= '0;
      occupancy <= '0;
    end else begin
      entries   <= entries_nxt;
      older     <= older_nxt;
      occupancy <= occ_nxt;
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: a vector table for basic issue/wakeup
// traffic plus hand-written sequences for full, age/busy, flush and reset.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic                     clk;
  logic                     rst;
  logic                     flush;
  logic                     disp_valid;
  logic                     disp_ready;
  logic [TAG_W-1:0]         disp_src1_tag;
  logic [TAG_W-1:0]         disp_src2_tag;
  logic                     disp_src1_rdy;
  logic                     disp_src2_rdy;
  logic [TAG_W-1:0]         disp_dst_tag;
  logic [FU_W-1:0]          disp_fu;
  logic [IMM_W-1:0]         disp_imm;
  logic [NUM_FUS-1:0]       wb_valid;
  logic [NUM_FUS*TAG_W-1:0] wb_tag;
  logic [NUM_FUS-1:0]       fu_busy;
  logic [NUM_FUS-1:0]       iss_valid;
  sel_uop_t [NUM_FUS-1:0]   iss_uop;
  logic [OCC_W-1:0]         occupancy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic             dv;
    logic             s1r;
    logic [TAG_W-1:0] s1t;
    logic [TAG_W-1:0] dst;
    logic [FU_W-1:0]  fu;
    logic [3:0]       wbv;
    logic [TAG_W-1:0] wbt;
    logic [3:0]       busy;
    logic [3:0]       e_iss;
    logic [3:0]       e_occ;
    logic             e_rdy;
    logic [FU_W-1:0]  cf;
    logic [TAG_W-1:0] e_dst;
  } vec_t;

  vec_t tbl [19];

  issue_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_src1_tag (disp_src1_tag),
    .disp_src2_tag (disp_src2_tag),
    .disp_src1_rdy (disp_src1_rdy),
    .disp_src2_rdy (disp_src2_rdy),
    .disp_dst_tag  (disp_dst_tag),
    .disp_fu       (disp_fu),
    .disp_imm      (disp_imm),
    .wb_valid      (wb_valid),
    .wb_tag        (wb_tag),
    .fu_busy       (fu_busy),
    .iss_valid     (iss_valid),
    .iss_uop       (iss_uop),
    .occupancy     (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush         = 1'b0;
    disp_valid    = 1'b0;
    disp_src1_tag = '0;
    disp_src2_tag = '0;
    disp_src1_rdy = 1'b0;
    disp_src2_rdy = 1'b0;
    disp_dst_tag  = '0;
    disp_fu       = '0;
    disp_imm      = '0;
    wb_valid      = '0;
    wb_tag        = '0;
    fu_busy       = '0;
  endtask

  // Drive one cycle's inputs after the falling edge, then check outputs
  // for that cycle; the inputs are consumed at the next rising edge.
  task automatic step(input string nm, input logic dv, input logic s1r,
                      input logic [TAG_W-1:0] s1t, input logic [TAG_W-1:0] dst,
                      input logic [FU_W-1:0] fu, input logic [3:0] wbv,
                      input logic [TAG_W-1:0] wbt, input logic [3:0] busy,
                      input logic fl, input logic [3:0] e_iss, input logic [3:0] e_occ,
                      input logic e_rdy, input logic [FU_W-1:0] cf,
                      input logic [TAG_W-1:0] e_dst);
    @(negedge clk);
    flush         = fl;
    disp_valid    = dv;
    disp_src1_tag = s1t;
    disp_src1_rdy = s1r;
    disp_src2_tag = '0;
    disp_src2_rdy = 1'b1;
    disp_dst_tag  = dst;
    disp_fu       = fu;
    disp_imm      = 32'h1000 + 32'(dst);
    wb_valid      = wbv;
    wb_tag        = {NUM_FUS{wbt}};
    fu_busy       = busy;
    #1;
    check({nm, ".iss_valid"}, 64'(iss_valid), 64'(e_iss));
    check({nm, ".occupancy"}, 64'(occupancy), 64'(e_occ));
    check({nm, ".disp_ready"}, 64'(disp_ready), 64'(e_rdy));
    if (e_iss[cf]) begin
      check({nm, ".dst"}, 64'(iss_uop[cf].dst_index), 64'(e_dst));
      check({nm, ".imm"}, 64'(iss_uop[cf].imm_val), 64'(32'h1000 + 32'(e_dst)));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    //         dv s1r s1t dst fu wbv      wbt busy     e_iss    occ rdy cf dst
    tbl[0]  = '{1, 1,  0, 10, 0, 4'b0000,  0, 4'b0000, 4'b0000, 0, 1, 0, 0};
    tbl[1]  = '{1, 1,  0, 11, 0, 4'b0000,  0, 4'b0000, 4'b0001, 1, 1, 0, 10};
    tbl[2]  = '{1, 1,  0, 12, 0, 4'b0000,  0, 4'b0000, 4'b0001, 1, 1, 0, 11};
    tbl[3]  = '{0, 0,  0,  0, 0, 4'b0000,  0, 4'b0000, 4'b0001, 1, 1, 0, 12};
    tbl[4]  = '{0, 0,  0,  0, 0, 4'b0000,  0, 4'b0000, 4'b0000, 0, 1, 0, 0};
    tbl[5]  = '{1, 0, 37, 20, 1, 4'b0000,  0, 4'b0000, 4'b0000, 0, 1, 0, 0};
    tbl[6]  = '{0, 0,  0,  0, 0, 4'b0000,  0, 4'b0000, 4'b0000, 1, 1, 0, 0};
    tbl[7]  = '{0, 0,  0,  0, 0, 4'b0100, 37, 4'b0000, 4'b0000, 1, 1, 0, 0};
    tbl[8]  = '{0, 0,  0,  0, 0, 4'b0000,  0, 4'b0000, 4'b0010, 1, 1, 1, 20};
    tbl[9]  = '{1, 0, 40, 21, 1, 4'b0001, 40, 4'b0000, 4'b0000, 0, 1, 0, 0};
    tbl[10] = '{0, 0,  0,  0, 0, 4'b0000,  0, 4'b0000, 4'b0010, 1, 1, 1, 21};
    tbl[11] = '{0, 0,  0,  0, 0, 4'b0000,  0, 4'b0000, 4'b0000, 0, 1, 0, 0};
    tbl[12] = '{1, 1,  0, 30, 2, 4'b0000,  0, 4'b0000, 4'b0000, 0, 1, 0, 0};
    tbl[13] = '{1, 1,  0, 31, 3, 4'b0000,  0, 4'b0000, 4'b0100, 1, 1, 2, 30};
    tbl[14] = '{0, 0,  0,  0, 0, 4'b0000,  0, 4'b0000, 4'b1000, 1, 1, 3, 31};
    tbl[15] = '{1, 1,  0, 40, 0, 4'b0000,  0, 4'b0000, 4'b0000, 0, 1, 0, 0};
    tbl[16] = '{0, 0,  0,  0, 0, 4'b0000,  0, 4'b0001, 4'b0000, 1, 1, 0, 0};
    tbl[17] = '{0, 0,  0,  0, 0, 4'b0000,  0, 4'b0000, 4'b0001, 1, 1, 0, 40};
    tbl[18] = '{0, 0,  0,  0, 0, 4'b0000,  0, 4'b0000, 4'b0000, 0, 1, 0, 0};

    for (int i = 0; i < 19; i++) begin
      step($sformatf("vec%0d", i), tbl[i].dv, tbl[i].s1r, tbl[i].s1t, tbl[i].dst,
           tbl[i].fu, tbl[i].wbv, tbl[i].wbt, tbl[i].busy, 1'b0, tbl[i].e_iss,
           tbl[i].e_occ, tbl[i].e_rdy, tbl[i].cf, tbl[i].e_dst);
    end

    // Fill with unready uops, hold a ready 9th, wake slot 3.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step($sformatf("fill%0d", i), 1'b1, 1'b0, TAG_W'(50 + i), TAG_W'(60 + i), 2'd0,
           4'b0000, '0, 4'b0000, 1'b0, 4'b0000, 4'(i), 1'b1, 2'd0, '0);
    end
    step("full_wake", 1'b1, 1'b1, 0, 99, 0, 4'b0010, 53, 4'b0000, 1'b0, 4'b0000, 8, 1'b0, 0, 0);
    step("full_iss",  1'b1, 1'b1, 0, 99, 0, 4'b0000,  0, 4'b0000, 1'b0, 4'b0001, 8, 1'b0, 0, 63);
    step("full_free", 1'b1, 1'b1, 0, 99, 0, 4'b0000,  0, 4'b0000, 1'b0, 4'b0000, 7, 1'b1, 0, 0);
    step("full_9th",  1'b0, 1'b0, 0,  0, 0, 4'b0000,  0, 4'b0000, 1'b0, 4'b0001, 8, 1'b0, 0, 99);

    // Age order on FU1 with a busy hold; FU2 traffic proceeds meanwhile.
    do_reset();
    step("age_a",    1'b1, 1'b0, 70, 90, 1, 4'b0000,  0, 4'b0000, 1'b0, 4'b0000, 0, 1'b1, 0, 0);
    step("age_b",    1'b1, 1'b0, 70, 91, 1, 4'b0000,  0, 4'b0000, 1'b0, 4'b0000, 1, 1'b1, 0, 0);
    step("age_c",    1'b1, 1'b0, 72, 92, 1, 4'b0000,  0, 4'b0000, 1'b0, 4'b0000, 2, 1'b1, 0, 0);
    step("age_wc",   1'b0, 1'b0,  0,  0, 0, 4'b1000, 72, 4'b0000, 1'b0, 4'b0000, 3, 1'b1, 0, 0);
    step("age_bsy1", 1'b1, 1'b1,  0, 80, 2, 4'b0000,  0, 4'b0010, 1'b0, 4'b0000, 3, 1'b1, 0, 0);
    step("age_bsy2", 1'b0, 1'b0,  0,  0, 0, 4'b0000,  0, 4'b0010, 1'b0, 4'b0100, 4, 1'b1, 2, 80);
    step("age_iss_c",1'b0, 1'b0,  0,  0, 0, 4'b0001, 70, 4'b0000, 1'b0, 4'b0010, 3, 1'b1, 1, 92);
    step("age_iss_a",1'b0, 1'b0,  0,  0, 0, 4'b0000,  0, 4'b0000, 1'b0, 4'b0010, 2, 1'b1, 1, 90);
    step("age_iss_b",1'b0, 1'b0,  0,  0, 0, 4'b0000,  0, 4'b0000, 1'b0, 4'b0010, 1, 1'b1, 1, 91);
    step("age_end",  1'b0, 1'b0,  0,  0, 0, 4'b0000,  0, 4'b0000, 1'b0, 4'b0000, 0, 1'b1, 0, 0);

    // Flush with four waiting entries and a concurrent ready dispatch.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step($sformatf("fl_fill%0d", i), 1'b1, 1'b0, 100, TAG_W'(i), 2'd0,
           4'b0000, '0, 4'b0000, 1'b0, 4'b0000, 4'(i), 1'b1, 2'd0, '0);
    end
    step("fl_flush", 1'b1, 1'b1, 0, 110, 0, 4'b0000,   0, 4'b0000, 1'b1, 4'b0000, 4, 1'b1, 0, 0);
    step("fl_after", 1'b0, 1'b0, 0,   0, 0, 4'b0001, 100, 4'b0000, 1'b0, 4'b0000, 0, 1'b1, 0, 0);
    step("fl_quiet1",1'b0, 1'b0, 0,   0, 0, 4'b0000,   0, 4'b0000, 1'b0, 4'b0000, 0, 1'b1, 0, 0);
    step("fl_quiet2",1'b0, 1'b0, 0,   0, 0, 4'b0000,   0, 4'b0000, 1'b0, 4'b0000, 0, 1'b1, 0, 0);

    // Asynchronous reset with five entries in flight.
    for (int i = 0; i < 5; i++) begin
      step($sformatf("rs_fill%0d", i), 1'b1, 1'b0, 120, TAG_W'(i), 2'd0,
           4'b0000, '0, 4'b0000, 1'b0, 4'b0000, 4'(i), 1'b1, 2'd0, '0);
    end
    step("rs_five", 1'b0, 1'b0, 0, 0, 0, 4'b0000, 0, 4'b0000, 1'b0, 4'b0000, 5, 1'b1, 0, 0);
    @(negedge clk);
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    check("rs_async.occupancy", 64'(occupancy), 64'd0);
    check("rs_async.iss_valid", 64'(iss_valid), 64'd0);
    check("rs_async.disp_ready", 64'(disp_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    step("rs_next",  1'b0, 1'b0, 0, 0, 0, 4'b0001, 120, 4'b0000, 1'b0, 4'b0000, 0, 1'b1, 0, 0);
    step("rs_quiet", 1'b0, 1'b0, 0, 0, 0, 4'b0000,   0, 4'b0000, 1'b0, 4'b0000, 0, 1'b1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Wakeup/select scheduler for the out-of-order core's reservation station. It holds up to RS_ENTRIES renamed micro-ops and tracks source-operand readiness by snooping physical-register tag broadcasts from the functional-unit writeback buses. Each cycle it grants the oldest ready micro-op to each non-busy FU. It sits between dispatch/rename and register read, and its issue payload feeds the RegRead stage.

## Interface
- RS_ENTRIES, 8, reservation-station depth (power of 2, ≥2)
- NUM_PREGS, 128, physical register count; TAG_W = $clog2(NUM_PREGS)
- NUM_FUS, 4, functional units; FU_W = $clog2(NUM_FUS)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous squash of all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  at least one free entry
- disp_src1_tag / disp_src2_tag  in  TAG_W each  source physical register tags
- disp_src1_rdy / disp_src2_rdy  in  1 each  source already available at rename
- disp_dst_tag  in  TAG_W  destination physical register tag
- disp_fu  in  FU_W  target FU index
- disp_imm  in  32  immediate value
- wb_valid  in  NUM_FUS  per-FU wakeup broadcast valid
- wb_tag  in  NUM_FUS×TAG_W  per-FU broadcast tag
- fu_busy  in  NUM_FUS  FU cannot accept this cycle
- iss_valid  out  NUM_FUS  per-FU grant
- iss_uop  out  NUM_FUS×Sel_uOP  src1_index, src2_index, imm_val, dst_index
- occupancy  out  $clog2(RS_ENTRIES)+1  count of valid entries

## Operation
- Entry state: valid, src1_tag/rdy, src2_tag/rdy, dst_tag, fu, imm. Age matrix older[i][j] (j is older than i).
- Dispatch fires when disp_valid && disp_ready && !flush. It allocates the lowest-index free entry k and sets row k to the current valid vector, after excluding entries issuing this cycle. It clears column k in every row.
- Dispatch bypass: a source whose tag matches any wb_valid/wb_tag in the dispatch cycle is written as ready.
- Wakeup: each valid entry ORs its srcN_rdy with a match against any valid broadcast. Multiple matches are harmless.
- Ready(i) = valid && src1_rdy && src2_rdy, all from registered state.
- Select per FU f: candidate(i) = Ready(i) && fu==f. The winner is the candidate with no older candidate. Assert iss_valid[f] iff a winner exists && !fu_busy[f].
- A granted entry is freed at the clock edge. At most one grant per FU and at most NUM_FUS grants per cycle.
- Flush clears all valid bits and the age matrix, and has priority over dispatch, wakeup and issue. iss_valid is still driven combinationally in the flush cycle; the consumer discards it.
- occupancy(next) = occupancy + dispatch − popcount(grants). It is 0 after flush.

## Timing
- Reset (async): all valid=0, age matrix=0, occupancy=0 → disp_ready=1, iss_valid=0.
- disp_ready depends only on registered state. Entries freed this cycle are reusable next cycle.
- Dispatch at edge N with both sources ready → earliest iss_valid in cycle N+1.
- Broadcast sampled at edge N → dependent entry eligible in cycle N+1. There is no same-cycle wake-and-issue.
- iss_valid/iss_uop are combinational from state plus fu_busy. The grant is consumed at the edge where iss_valid=1.
- With fu_busy[f]=1, the winner is held; it retains age priority and issues on the first cycle busy drops.
- Full (occupancy==RS_ENTRIES): disp_ready=0, dispatch ignored, even if issue frees an entry in the same cycle.

## Structure
- CORE_PKG: RS_ENTRIES, NUM_PREGS, NUM_FUS parameters. Extend Sel_uOP with dst_index. Add an rs_entry_t packed struct.
- Sub-module rs_age_select: candidate vector + age matrix → one-hot grant. Instantiated NUM_FUS times.

## Test plan
- Reset mid-traffic with 5 entries valid → next cycle: occupancy=0, iss_valid=0, disp_ready=1.
- Dispatch 3 ready uops to FU0 at cycles 0,1,2 → iss_valid[0] at 1,2,3 in dispatch order. dst_index tracks disp_dst_tag (10,11,12).
- Dispatch uop with src1 tag 37 not ready, then wb_valid[2]=1, wb_tag[2]=37 at cycle 5 → iss at 6. Repeat with wb in the dispatch cycle → iss at next cycle.
- Fill 8 unready entries → disp_ready=0 and a 9th request is held. Wake entry 3 → it issues, and disp_ready=1 the following cycle.
- Ages A<B<C on FU1, wake C then A/B together, fu_busy[1]=1 for 2 cycles → C issues first when busy drops, then A, then B. FU2 grants are unaffected meanwhile.
- Flush with 4 valid entries and concurrent disp_valid → occupancy=0, nothing issues after, and the concurrent dispatch is dropped.
